// File: rtl/tt_sel_seq.sv
// tt_sel_seq: turns "select design at address A" requests into ctrl_sel_rst_n / ctrl_sel_inc / ctrl_ena sequences. Optional macro TT_SEL_SEQ_FASTPATH_EN skips the chain reset when the target is at or above the current address.
module tt_sel_seq #(
  parameter int ADDR_W  = 10,
  parameter int DIV     = 2,
  parameter int RST_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);
  typedef enum logic [2:0] {RST0, IDLE, ACTIVE, DIS, RST, INC_HI, INC_LO, FIN} state_t;
  localparam logic [15:0] DIV_L = 16'(DIV - 1);
  localparam logic [15:0] RST_L = 16'(RST_CYC - 1);
  state_t            state;
  logic [15:0]       tmr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] tgt;
  logic              ena_q;
  logic              hs;
`ifdef TT_SEL_SEQ_FASTPATH_EN
  logic              fast;
`endif
  assign hs = req_valid & req_ready;
  // Sequencer: every output is a register written on entry to the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RST0;
      tmr            <= '0;
      cnt            <= '0;
      tgt            <= '0;
      ena_q          <= 1'b0;
      req_ready      <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
      cur_addr       <= '0;
      cur_valid      <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
`ifdef TT_SEL_SEQ_FASTPATH_EN
      fast           <= 1'b0;
`endif
    end else begin
      tmr  <= tmr + 16'd1;
      done <= 1'b0;
      case (state)
        RST0: if (tmr == RST_L) begin
          state          <= IDLE;
          tmr            <= '0;
          ctrl_sel_rst_n <= 1'b1;
          req_ready      <= 1'b1;
        end
        IDLE, ACTIVE: if (hs) begin
          state     <= DIS;
          tmr       <= '0;
          tgt       <= req_addr;
          ena_q     <= req_ena;
          cnt       <= req_addr;
          cur_valid <= 1'b0;
          ctrl_ena  <= 1'b0;
          busy      <= 1'b1;
          req_ready <= 1'b0;
`ifdef TT_SEL_SEQ_FASTPATH_EN
          fast      <= cur_valid && req_addr >= cur_addr;
          if (cur_valid && req_addr >= cur_addr) cnt <= req_addr - cur_addr;
`endif
        end
        DIS: if (tmr == 16'd1) begin
          tmr <= '0;
`ifdef TT_SEL_SEQ_FASTPATH_EN
          if (fast) begin
            state        <= cnt == '0 ? FIN : INC_HI;
            ctrl_sel_inc <= cnt != '0;
            done         <= cnt == '0;
            cur_valid    <= cnt == '0;
            if (cnt == '0) cur_addr <= tgt;
          end else begin
            state          <= RST;
            ctrl_sel_rst_n <= 1'b0;
          end
`else
          state          <= RST;
          ctrl_sel_rst_n <= 1'b0;
`endif
        end
        RST: if (tmr == RST_L) begin
          tmr            <= '0;
          ctrl_sel_rst_n <= 1'b1;
          state          <= cnt == '0 ? FIN : INC_HI;
          ctrl_sel_inc   <= cnt != '0;
          done           <= cnt == '0;
          cur_valid      <= cnt == '0;
          if (cnt == '0) cur_addr <= tgt;
        end
        INC_HI: if (tmr == DIV_L) begin
          tmr          <= '0;
          state        <= INC_LO;
          ctrl_sel_inc <= 1'b0;
        end
        INC_LO: if (tmr == DIV_L) begin
          tmr          <= '0;
          cnt          <= cnt - 1'b1;
          state        <= cnt == ADDR_W'(1) ? FIN : INC_HI;
          ctrl_sel_inc <= cnt != ADDR_W'(1);
          done         <= cnt == ADDR_W'(1);
          cur_valid    <= cnt == ADDR_W'(1);
          if (cnt == ADDR_W'(1)) cur_addr <= tgt;
        end
        FIN: begin
          state     <= ena_q ? ACTIVE : IDLE;
          ctrl_ena  <= ena_q;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= RST0;
      endcase
    end
  end
endmodule

// File: doc/tt_sel_seq.md
Name: tt_sel_seq

Overview:
- Upstream driver for the mux control pins ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena.
- Converts a single "select design at address A" request into the pin sequence the controller chain consumes:
  - disable the current design,
  - pulse the select reset,
  - emit A increment pulses,
  - optionally raise ena.
- Sits in the harness/management side, in place of hand-driven stimulus.
- Tracks which address is currently selected.

Parameters:
- ADDR_W, 10, address width; {mux_id[ADDR_W-1:5], blk_id[4:0]}.
- DIV, 2, clk cycles per half-period of a ctrl_sel_inc pulse (>=1).
- RST_CYC, 4, clk cycles ctrl_sel_rst_n is held low per reset (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at posedge.
- req_addr  in  ADDR_W  target address.
- req_ena  in  1  1: raise ctrl_ena after selection; 0: select only.
- done  out  1  one-cycle pulse when a sequence completes.
- busy  out  1  sequence in progress.
- cur_addr  out  ADDR_W  address currently selected.
- cur_valid  out  1  cur_addr is meaningful.
- ctrl_sel_rst_n  out  1  select-chain reset, active low.
- ctrl_sel_inc  out  1  select increment pulse.
- ctrl_ena  out  1  enable for the selected design.

Behaviour:
- Reset values (asynchronous, while rst_n low):
  - ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0.
  - cur_valid=0, cur_addr=0, done=0, busy=0, req_ready=0.
  - State RST0: holds ctrl_sel_rst_n low for RST_CYC cycles after release, then goes to IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- States and transitions:
  - RST0 -> IDLE.
  - IDLE: req_ready=1, ctrl_ena=0, ctrl_sel_rst_n=1. On handshake, latch req_addr/req_ena, clear cur_valid, go to DIS.
  - ACTIVE: req_ready=1, ctrl_ena=1. On handshake, latch the request, drop ctrl_ena the next cycle, clear cur_valid, go to DIS.
  - DIS: 2 cycles, ctrl_ena=0, then RST.
  - RST: ctrl_sel_rst_n=0 for RST_CYC cycles; load down-counter cnt=A; then INC_HI (or FIN if A==0).
  - INC_HI: ctrl_sel_inc=1 for DIV cycles -> INC_LO.
  - INC_LO: ctrl_sel_inc=0 for DIV cycles; decrement cnt; if cnt becomes 0 go to FIN, else INC_HI.
  - FIN: 1 cycle. done=1, cur_addr=A, cur_valid=1. Next state is ACTIVE (ctrl_ena=1) if req_ena, else IDLE.
- busy=1 in every state except IDLE and ACTIVE; req_ready=~busy (0 in RST0).
- Latency: ctrl_ena rises (or IDLE is re-entered) 2+RST_CYC+2*DIV*A+1 cycles after the handshake edge.
  - Example, A=3 with defaults: 19 cycles.
  - Example, A=0: 7 cycles.
  - ctrl_sel_inc never rises in the same cycle ctrl_sel_rst_n is low.
- Width rules:
  - cnt is ADDR_W bits.
  - A=2^ADDR_W-1 yields exactly 1023 pulses (default width); no wrap.
- req_valid while busy is ignored (not accepted, not queued).
- A request equal to cur_addr still runs the full sequence (without the optional feature).
- rst_n asserted mid-sequence: immediate return to reset values, and the partial selection is discarded.

Optional Feature:
- Macro: TT_SEL_SEQ_FASTPATH_EN.
- Defined:
  - A handshake with cur_valid=1 and req_addr>=cur_addr skips RST.
  - Path is DIS (2 cycles) -> (req_addr-cur_addr) INC pulses -> FIN.
  - Latency is 2+2*DIV*(req_addr-cur_addr)+1.
  - req_addr==cur_addr gives zero pulses and FIN 3 cycles after the handshake.
  - req_addr<cur_addr, or cur_valid=0, uses the full path.
- Undefined: every request uses the full reset path, and the behaviour is identical to the base spec.

Test Plan:
- Reset release, no request:
  - ctrl_sel_rst_n low for 4 cycles then high.
  - req_ready=1, ctrl_ena=0, ctrl_sel_inc never toggles.
- Request A=384 (mux 12, blk 0), req_ena=1:
  - exactly 384 ctrl_sel_inc rising edges, each 2 high / 2 low.
  - ctrl_ena=1 at cycle 2+4+1536+1=1543; done pulses once.
  - cur_addr=384, cur_valid=1.
- From ACTIVE, request A=0, req_ena=0:
  - ctrl_ena falls the cycle after the handshake.
  - 4-cycle reset, zero inc pulses.
  - IDLE at cycle 7, cur_addr=0.
- req_valid held while busy with a different address: not accepted, busy=1; accepted at the first ready cycle after done.
- rst_n pulsed low during the INC_HI of pulse 10 of A=20:
  - all ctrl outputs go to reset values immediately.
  - cur_valid=0, no done pulse.
- With TT_SEL_SEQ_FASTPATH_EN:
  - cur_addr=5 -> request 8 gives 3 pulses, no ctrl_sel_rst_n low, done at cycle 15.
  - request 2 gives the full reset path with 2 pulses.
